// File: rtl/duty_ramp.sv
// Slew-limited duty command for a PWM stage: duty moves at most STEP per PWM period toward the target.
// Define DUTY_RAMP_FAULT_EN to build the overcurrent fault latch (ovr_i path and FAULT state).
module duty_ramp #(
    parameter logic [10:0] STEP     = 11'd8,
    parameter logic [10:0] MAX_DUTY = 11'd1945
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [10:0] target_duty,
    input  logic        PWM_synch,
    input  logic        ovr_i,
    output logic [10:0] duty,
    output logic        at_target,
    output logic        fault
);

    typedef enum logic [1:0] {IDLE, RAMP, HOLD, FAULT} state_t;

    state_t      state, state_next;
    logic [10:0] tgt, step_val, duty_next;
    logic        at_target_next, fault_next;
    logic [11:0] cur_w, tgt_w, diff_w, sum_w;

`ifndef DUTY_RAMP_FAULT_EN
    logic unused_ovr;
    assign unused_ovr = ovr_i;
`endif

    always_comb begin
        tgt = '0;
        if (enable && state != FAULT)
            tgt = (target_duty > MAX_DUTY) ? MAX_DUTY : target_duty;
    end

    // One slew step toward tgt; the extra bit keeps the sum and difference from wrapping.
    always_comb begin
        cur_w  = {1'b0, duty};
        tgt_w  = {1'b0, tgt};
        diff_w = '0;
        sum_w  = cur_w;
        if (tgt_w > cur_w) begin
            diff_w = tgt_w - cur_w;
            sum_w  = (diff_w <= {1'b0, STEP}) ? tgt_w : cur_w + {1'b0, STEP};
        end else begin
            diff_w = cur_w - tgt_w;
            sum_w  = (diff_w <= {1'b0, STEP}) ? tgt_w : cur_w - {1'b0, STEP};
        end
        if (sum_w > {1'b0, MAX_DUTY})
            sum_w = {1'b0, MAX_DUTY};
        step_val = sum_w[10:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            duty      <= '0;
            at_target <= 1'b1;
            fault     <= 1'b0;
        end else begin
            state     <= state_next;
            duty      <= duty_next;
            at_target <= at_target_next;
            fault     <= fault_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (tgt != '0)
                    state_next = RAMP;
            end
            RAMP: begin
                if (PWM_synch && step_val == tgt)
                    state_next = enable ? HOLD : IDLE;
            end
            HOLD: begin
                if (PWM_synch && step_val == tgt)
                    state_next = enable ? HOLD : IDLE;
                else if (duty != tgt)
                    state_next = RAMP;
            end
            FAULT: begin
`ifdef DUTY_RAMP_FAULT_EN
                if (!enable && !ovr_i)
                    state_next = IDLE;
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
`ifdef DUTY_RAMP_FAULT_EN
        if (ovr_i)
            state_next = FAULT;
`endif
    end

    // Overcurrent wins over everything else and zeroes duty without waiting for the PWM boundary.
    always_comb begin
        duty_next  = duty;
        fault_next = 1'b0;
        case (state)
            IDLE:       duty_next = '0;
            RAMP, HOLD: if (PWM_synch) duty_next = step_val;
            FAULT:      duty_next = '0;
            default:    duty_next = '0;
        endcase
`ifdef DUTY_RAMP_FAULT_EN
        fault_next = fault;
        if (state == FAULT && !enable && !ovr_i)
            fault_next = 1'b0;
        if (ovr_i) begin
            duty_next  = '0;
            fault_next = 1'b1;
        end
`endif
        at_target_next = (duty_next == tgt);
    end

endmodule
